// File: rtl/definitions.sv
// definitions: constants and Gray-code helpers shared by the read side
// (rptr_empty) and the write side (wptr_full) of the async FIFO.
//   ADDRSIZE   RAM address width; FIFO depth is 2**ADDRSIZE
//   PTRSIZE    pointer width (one extra MSB to tell laps apart)
//   bin2gray() binary -> Gray at pointer width
//   gray2bin() Gray -> binary at pointer width
package definitions;

  localparam int ADDRSIZE = 4;
  localparam int PTRSIZE  = ADDRSIZE + 1;

  function automatic logic [PTRSIZE-1:0] bin2gray(input logic [PTRSIZE-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic logic [PTRSIZE-1:0] gray2bin(input logic [PTRSIZE-1:0] gray);
    logic [PTRSIZE-1:0] bin_v;
    bin_v = {PTRSIZE{1'b0}};
    for (int i = 0; i < PTRSIZE; i++) begin
      bin_v[i] = ^(gray >> i);
    end
    return bin_v;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary converter of parameterized width.
//   gray  in   W   Gray-coded value
//   bin   out  W   binary equivalent
// Each binary bit is the XOR of its Gray bit and every more-significant Gray
// bit; writing it as a reduction of the shifted input keeps every bit a
// direct function of the input instead of chaining through bin itself.
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/rptr_empty.sv
// rptr_empty: read-domain pointer and empty-flag generator of the async FIFO.
//   rclk           in   1           read clock, all state on posedge
//   rrst           in   1           synchronous active-high reset
//   rq2_wptr       in   ADDRSIZE+1  Gray write pointer, already synced to rclk
//   rinc           in   1           read request
//   raddr          out  ADDRSIZE    RAM read address
//   rptr           out  ADDRSIZE+1  registered Gray read pointer (to sync_r2w)
//   rempty         out  1           registered empty flag
//   ralmost_empty  out  1           registered, occupancy <= AE_LEVEL
//   runderflow     out  1           sticky, read requested while empty
module rptr_empty
  import definitions::*;
#(
  parameter int ADDRSIZE = definitions::ADDRSIZE,
  parameter int AE_LEVEL = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic                rinc,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic                runderflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] rbin_r;
  logic [PW-1:0] rptr_r;
  logic          rempty_r;
  logic          ralmost_empty_r;
  logic          runderflow_r;

  logic          rd_ok_s;
  logic [PW-1:0] rbinnext_s;
  logic [PW-1:0] rgraynext_s;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] occ_s;
  logic          empty_next_s;
  logic          ae_next_s;

  gray2bin_conv #(.W(PW)) u_wbin_conv (
    .gray (rq2_wptr),
    .bin  (wbin_s)
  );

  // Next-pointer and next-flag computation for the coming edge.
  always_comb begin
    rd_ok_s      = rinc & ~rempty_r;
    rbinnext_s   = rbin_r + {{(PW-1){1'b0}}, rd_ok_s};
    rgraynext_s  = (rbinnext_s >> 1) ^ rbinnext_s;
    // Modulo-2**PW difference; the extra MSB keeps a full lap (2**ADDRSIZE)
    // distinct from zero.
    occ_s        = wbin_s - rbinnext_s;
    empty_next_s = (rgraynext_s == rq2_wptr);
    ae_next_s    = (occ_s <= PW'(AE_LEVEL));
  end

  // Pointer, flag and sticky-error registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_r          <= {PW{1'b0}};
      rptr_r          <= {PW{1'b0}};
      rempty_r        <= 1'b1;
      ralmost_empty_r <= 1'b1;
      runderflow_r    <= 1'b0;
    end else begin
      rbin_r          <= rbinnext_s;
      rptr_r          <= rgraynext_s;
      rempty_r        <= empty_next_s;
      ralmost_empty_r <= ae_next_s;
      runderflow_r    <= runderflow_r | (rinc & rempty_r);
    end
  end

  // raddr is a slice of the binary register, so it adds no latency.
  assign raddr         = rbin_r[ADDRSIZE-1:0];
  assign rptr          = rptr_r;
  assign rempty        = rempty_r;
  assign ralmost_empty = ralmost_empty_r;
  assign runderflow    = runderflow_r;

endmodule

// File: tb/tb_rptr_empty.sv
// tb_rptr_empty: directed vectors for rptr_empty (ADDRSIZE=4, AE_LEVEL=2).
// The driver applies one vector per cycle on the falling edge and queues the
// values expected after the next rising edge; a monitor pops and compares.
module tb_rptr_empty;

  typedef struct {
    int         step;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       rae;
    logic       ruf;
  } exp_t;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic [4:0] rq2_wptr = 5'b00000;
  logic       rinc = 1'b0;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic       ralmost_empty;
  logic       runderflow;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  rptr_empty #(.ADDRSIZE(4), .AE_LEVEL(2)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .rq2_wptr      (rq2_wptr),
    .rinc          (rinc),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string name, input int stp, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, stp, got, want);
    end
  endtask

  // Monitor: compares DUT outputs after each rising edge with queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge rclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("raddr",         e.step, {4'h0, raddr},         {4'h0, e.raddr});
        chk("rptr",          e.step, {3'h0, rptr},          {3'h0, e.rptr});
        chk("rempty",        e.step, {7'h0, rempty},        {7'h0, e.rempty});
        chk("ralmost_empty", e.step, {7'h0, ralmost_empty}, {7'h0, e.rae});
        chk("runderflow",    e.step, {7'h0, runderflow},    {7'h0, e.ruf});
      end
    end
  end

  task automatic vec(input logic rst, input logic inc, input logic [4:0] w,
                     input logic [3:0] ea, input logic [4:0] ep,
                     input logic ee, input logic eae, input logic euf);
    exp_t e;
    @(negedge rclk);
    rrst     = rst;
    rinc     = inc;
    rq2_wptr = w;
    step_no++;
    e.step   = step_no;
    e.raddr  = ea;
    e.rptr   = ep;
    e.rempty = ee;
    e.rae    = eae;
    e.ruf    = euf;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [4:0] b;
    logic [4:0] occ;
    // 1 reset
    vec(1'b1, 1'b0, 5'b00000, 4'd0, 5'b00000, 1'b1, 1'b1, 1'b0);
    // 2 basic: three entries, three reads
    vec(1'b0, 1'b0, 5'b00010, 4'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
    vec(1'b0, 1'b1, 5'b00010, 4'd1, 5'b00001, 1'b0, 1'b1, 1'b0);
    vec(1'b0, 1'b1, 5'b00010, 4'd2, 5'b00011, 1'b0, 1'b1, 1'b0);
    vec(1'b0, 1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1, 1'b1, 1'b0);
    // 3 underflow: pointers hold, sticky flag
    vec(1'b0, 1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1, 1'b1, 1'b1);
    vec(1'b0, 1'b0, 5'b00010, 4'd3, 5'b00010, 1'b1, 1'b1, 1'b1);
    vec(1'b0, 1'b0, 5'b00010, 4'd3, 5'b00010, 1'b1, 1'b1, 1'b1);
    vec(1'b1, 1'b0, 5'b00000, 4'd0, 5'b00000, 1'b1, 1'b1, 1'b0);
    // 4 almost empty: five entries
    vec(1'b0, 1'b0, 5'b00111, 4'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
    vec(1'b0, 1'b1, 5'b00111, 4'd1, 5'b00001, 1'b0, 1'b0, 1'b0);
    vec(1'b0, 1'b1, 5'b00111, 4'd2, 5'b00011, 1'b0, 1'b0, 1'b0);
    vec(1'b0, 1'b1, 5'b00111, 4'd3, 5'b00010, 1'b0, 1'b1, 1'b0);
    vec(1'b0, 1'b1, 5'b00111, 4'd4, 5'b00110, 1'b0, 1'b1, 1'b0);
    vec(1'b0, 1'b1, 5'b00111, 4'd5, 5'b00111, 1'b1, 1'b1, 1'b0);
    // 6 reset mid-read with occupancy 4 (write pointer gray(9))
    vec(1'b0, 1'b0, 5'b01101, 4'd5, 5'b00111, 1'b0, 1'b0, 1'b0);
    vec(1'b1, 1'b1, 5'b01101, 4'd0, 5'b00000, 1'b1, 1'b1, 1'b0);
    vec(1'b0, 1'b0, 5'b00000, 4'd0, 5'b00000, 1'b1, 1'b1, 1'b0);
    // 5 wrap: first lap, write side at 16 (full depth, not empty)
    vec(1'b0, 1'b0, 5'b11000, 4'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      b   = 5'(k);
      occ = 5'(16 - k);
      vec(1'b0, 1'b1, 5'b11000, b[3:0], (b >> 1) ^ b, (k == 16), (occ <= 5'd2), 1'b0);
    end
    // second lap: write side at 32 (gray 0), occupancy 16 again
    vec(1'b0, 1'b0, 5'b00000, 4'd0, 5'b11000, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      b   = 5'(16 + k);
      occ = 5'(16 - k);
      vec(1'b0, 1'b1, 5'b00000, b[3:0], (b >> 1) ^ b, (k == 16), (occ <= 5'd2), 1'b0);
    end
    // read and write-pointer change in the same cycle
    vec(1'b0, 1'b0, 5'b00001, 4'd0, 5'b00000, 1'b0, 1'b1, 1'b0);
    vec(1'b0, 1'b1, 5'b00011, 4'd1, 5'b00001, 1'b0, 1'b1, 1'b0);
    vec(1'b0, 1'b1, 5'b00011, 4'd2, 5'b00011, 1'b1, 1'b1, 1'b0);
    vec(1'b0, 1'b0, 5'b00011, 4'd2, 5'b00011, 1'b1, 1'b1, 1'b0);

    // bounded drain of the scoreboard
    repeat (4) @(posedge rclk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
